// File: rtl/data_mem_loader.sv
// Byte-stream loader for data memory: packs bytes little-endian into 32-bit words and writes them.
// Optional LOADER_CHECKSUM_EN adds a 16-bit running sum of accepted bytes.
module data_mem_loader #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 20,
    parameter int MEM_SIZE      = 16384
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic [ADDRESS_WIDTH-1:0] length,
    input  logic                     in_valid,
    input  logic [7:0]               in_byte,
    output logic                     in_ready,
    output logic                     mem_we,
    output logic                     mem_be,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [ADDRESS_WIDTH-1:0] byte_count
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [15:0]              checksum
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, FINISH} state_t;

    localparam logic [ADDRESS_WIDTH-1:0] MEM_LIMIT = ADDRESS_WIDTH'(MEM_SIZE);

    state_t                   state, next_state;
    logic [ADDRESS_WIDTH-1:0] pointer, len_q, aligned_base, next_pointer;
    logic [1:0]               lane;
    logic [DATA_WIDTH-1:0]    packer;
    logic                     xfer, last_byte, base_oob, next_oob;

    assign aligned_base = base_addr & ~ADDRESS_WIDTH'(3);
    assign next_pointer = pointer + ADDRESS_WIDTH'(4);
    assign base_oob     = aligned_base >= MEM_LIMIT;
    assign next_oob     = next_pointer >= MEM_LIMIT;
    // Handshake qualified by state directly so the FSM block has no combinational loop through in_ready.
    assign xfer         = in_valid && (state == LOAD);
    assign last_byte    = (byte_count + ADDRESS_WIDTH'(1)) == len_q;

    assign mem_be         = 1'b0;
    assign mem_address    = pointer;
    assign mem_write_data = packer;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (length == '0)   next_state = FINISH;
                    else if (!base_oob) next_state = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (xfer && (lane == 2'd3 || last_byte)) next_state = WRITE;
            end
            WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
                if (byte_count == len_q) next_state = FINISH;
                else if (next_oob)       next_state = IDLE;
                else                     next_state = LOAD;
            end
            FINISH: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pointer    <= '0;
            len_q      <= '0;
            byte_count <= '0;
            lane       <= '0;
            packer     <= '0;
            error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pointer    <= aligned_base;
                        len_q      <= length;
                        byte_count <= '0;
                        lane       <= '0;
                        packer     <= '0;
                        error      <= (length != '0) && base_oob;
`ifdef LOADER_CHECKSUM_EN
                        checksum   <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        packer[{lane, 3'b000} +: 8] <= in_byte;
                        lane       <= lane + 2'd1;
                        byte_count <= byte_count + ADDRESS_WIDTH'(1);
`ifdef LOADER_CHECKSUM_EN
                        checksum   <= checksum + {8'h00, in_byte};
`endif
                    end
                end
                WRITE: begin
                    packer  <= '0;
                    lane    <= '0;
                    pointer <= next_pointer;
                    if (byte_count != len_q && next_oob) error <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_loader.sv
// Directed bench for data_mem_loader: table of load transactions plus hand-written reset/start sequences.
module tb_data_mem_loader;

    localparam int AW = 20;
    localparam int DW = 32;
    localparam int MS = 16384;
    localparam int WINDOW = 30;

    logic          clk = 1'b0;
    logic          rst, start, in_valid;
    logic [AW-1:0] base_addr, length;
    logic [7:0]    in_byte;
    logic          in_ready, mem_we, mem_be, busy, done, error;
    logic [AW-1:0] mem_address, byte_count;
    logic [DW-1:0] mem_write_data;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0]   checksum;
`endif

    int tests = 0;
    int fails = 0;

    data_mem_loader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_SIZE(MS)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
        .mem_we(mem_we), .mem_be(mem_be), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .busy(busy), .done(done), .error(error),
        .byte_count(byte_count)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] base;
        logic [AW-1:0] len;
        logic [63:0]   bytes;     // byte i offered in bits [8i+7:8i]
        logic          gap;       // toggle in_valid every other cycle
        logic [1:0]    nw;        // expected number of writes
        logic [AW-1:0] a0, a1;
        logic [31:0]   d0, d1;
        logic          exp_done;
        logic          exp_err;
        logic [AW-1:0] exp_bc;
        logic [15:0]   csum;
    } vec_t;

    vec_t vecs [8];

    task automatic run_vec(input int id, input vec_t v);
        int idx, nw, nd, wcyc, dcyc;
        logic [AW-1:0] wa [2];
        logic [31:0]   wd [2];
        logic offer;
        idx = 0; nw = 0; nd = 0; wcyc = -1; dcyc = -1;
        wa[0] = '0; wa[1] = '0; wd[0] = '0; wd[1] = '0;
        @(negedge clk);
        start = 1'b1; base_addr = v.base; length = v.len; in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < WINDOW; c++) begin
            if (mem_we) begin
                if (nw < 2) begin wa[nw] = mem_address; wd[nw] = mem_write_data; end
                nw++;
                wcyc = c;
            end
            if (done) begin nd++; dcyc = c; end
            offer = (idx < 8) && !(v.gap && c[0]);
            in_valid = offer;
            in_byte = (idx < 8) ? v.bytes[idx*8 +: 8] : 8'h00;
            if (offer && in_ready) idx++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check($sformatf("v%0d write_count", id), nw, {30'd0, v.nw});
        if (v.nw >= 1) begin
            check($sformatf("v%0d addr0", id), wa[0], v.a0);
            check($sformatf("v%0d data0", id), wd[0], v.d0);
        end
        if (v.nw >= 2) begin
            check($sformatf("v%0d addr1", id), wa[1], v.a1);
            check($sformatf("v%0d data1", id), wd[1], v.d1);
        end
        check($sformatf("v%0d done_count", id), nd, v.exp_done ? 1 : 0);
        if (v.exp_done && v.nw != 0)
            check($sformatf("v%0d done_latency", id), dcyc - wcyc, 1);
        check($sformatf("v%0d error", id), error, v.exp_err);
        check($sformatf("v%0d byte_count", id), byte_count, v.exp_bc);
        check($sformatf("v%0d accepted", id), idx, v.exp_bc);
        check($sformatf("v%0d busy_end", id), busy, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        check($sformatf("v%0d checksum", id), checksum, v.csum);
`endif
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " in_ready"}, in_ready, 1'b0);
        check({tag, " mem_we"}, mem_we, 1'b0);
        check({tag, " mem_be"}, mem_be, 1'b0);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " done"}, done, 1'b0);
        check({tag, " error"}, error, 1'b0);
        check({tag, " mem_address"}, mem_address, 32'h0);
        check({tag, " mem_write_data"}, mem_write_data, 32'h0);
        check({tag, " byte_count"}, byte_count, 32'h0);
`ifdef LOADER_CHECKSUM_EN
        check({tag, " checksum"}, checksum, 32'h0);
`endif
    endtask

    initial begin
        vecs[0] = '{base: 20'h10, len: 20'd8, bytes: 64'h0807060504030201, gap: 1'b0, nw: 2'd2,
                    a0: 20'h10, a1: 20'h14, d0: 32'h04030201, d1: 32'h08070605,
                    exp_done: 1'b1, exp_err: 1'b0, exp_bc: 20'd8, csum: 16'h0024};
        vecs[1] = '{base: 20'h40, len: 20'd6, bytes: 64'h0000FFEEDDCCBBAA, gap: 1'b0, nw: 2'd2,
                    a0: 20'h40, a1: 20'h44, d0: 32'hDDCCBBAA, d1: 32'h0000FFEE,
                    exp_done: 1'b1, exp_err: 1'b0, exp_bc: 20'd6, csum: 16'h04FB};
        vecs[2] = '{base: 20'h03, len: 20'd4, bytes: 64'h9999999944332211, gap: 1'b0, nw: 2'd1,
                    a0: 20'h00, a1: 20'h0, d0: 32'h44332211, d1: 32'h0,
                    exp_done: 1'b1, exp_err: 1'b0, exp_bc: 20'd4, csum: 16'h00AA};
        vecs[3] = '{base: 20'(MS - 4), len: 20'd8, bytes: 64'h0807060504030201, gap: 1'b0, nw: 2'd1,
                    a0: 20'(MS - 4), a1: 20'h0, d0: 32'h04030201, d1: 32'h0,
                    exp_done: 1'b0, exp_err: 1'b1, exp_bc: 20'd4, csum: 16'h000A};
        vecs[4] = '{base: 20'h20, len: 20'd3, bytes: 64'h000000000001FFFF, gap: 1'b1, nw: 2'd1,
                    a0: 20'h20, a1: 20'h0, d0: 32'h0001FFFF, d1: 32'h0,
                    exp_done: 1'b1, exp_err: 1'b0, exp_bc: 20'd3, csum: 16'h01FF};
        vecs[5] = '{base: 20'h100, len: 20'd5, bytes: 64'h7777775443322110, gap: 1'b1, nw: 2'd2,
                    a0: 20'h100, a1: 20'h104, d0: 32'h43322110, d1: 32'h00000054,
                    exp_done: 1'b1, exp_err: 1'b0, exp_bc: 20'd5, csum: 16'h00FA};
        vecs[6] = '{base: 20'(MS), len: 20'd4, bytes: 64'h0807060504030201, gap: 1'b0, nw: 2'd0,
                    a0: 20'h0, a1: 20'h0, d0: 32'h0, d1: 32'h0,
                    exp_done: 1'b0, exp_err: 1'b1, exp_bc: 20'd0, csum: 16'h0000};
        vecs[7] = '{base: 20'h08, len: 20'd0, bytes: 64'h0807060504030201, gap: 1'b0, nw: 2'd0,
                    a0: 20'h0, a1: 20'h0, d0: 32'h0, d1: 32'h0,
                    exp_done: 1'b1, exp_err: 1'b0, exp_bc: 20'd0, csum: 16'h0000};

        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; in_valid = 1'b0; in_byte = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_state("init");

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // start while loading is ignored; the original load completes unchanged
        @(negedge clk); start = 1'b1; base_addr = 20'h60; length = 20'd4;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; in_byte = 8'h11;
        @(negedge clk); start = 1'b1; base_addr = 20'h200; length = 20'd0; in_byte = 8'h22;
        @(negedge clk); start = 1'b0; in_byte = 8'h33;
        @(negedge clk); in_byte = 8'h44;
        @(negedge clk); in_valid = 1'b0;
        check("busy_start mem_we", mem_we, 1'b1);
        check("busy_start addr", mem_address, 32'h60);
        check("busy_start data", mem_write_data, 32'h44332211);
        @(negedge clk);
        check("busy_start done", done, 1'b1);
        check("busy_start byte_count", byte_count, 32'd4);

        // reset mid-load discards the partial word
        @(negedge clk); start = 1'b1; base_addr = 20'h80; length = 20'd8;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; in_byte = 8'hA1;
        @(negedge clk); in_byte = 8'hA2;
        @(negedge clk); in_valid = 1'b0; rst = 1'b1;
        check("midload byte_count", byte_count, 32'd2);
        @(negedge clk); rst = 1'b0;
        check_reset_state("midload_rst");
        start = 1'b1; base_addr = 20'h10; length = 20'd0;
        @(negedge clk); start = 1'b0;
        check("zero_len done", done, 1'b1);
        check("zero_len mem_we", mem_we, 1'b0);
        @(negedge clk);
        check("zero_len done_pulse", done, 1'b0);
        check("zero_len busy", busy, 1'b0);
        check("zero_len mem_we2", mem_we, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
